axi_read_decoder: RTL and testbench

// - Slave-side end of the AXI read path: takes the single AR stream already selected by the bus arbiter,

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_default_slave.sv | 45 ++++
 rtl/axi_read_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_read_decoder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-path types and the default address map for the read decoder.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 8;

    localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] S0_MASK_DEF = 32'h0000_FFFF;
    localparam logic [31:0] S1_BASE_DEF = 32'h0001_0000;
    localparam logic [31:0] S1_MASK_DEF = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        TGT_S0  = 2'd0,
        TGT_S1  = 2'd1,
        TGT_DEF = 2'd2
    } target_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DERR = 2'd3
    } state_t;

endpackage

// File: rtl/axi_default_slave.sv
// Default slave: answers unmapped reads with ARLEN+1 DECERR beats carrying the latched ID.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              i_en,
    input  logic [ID_W-1:0]   i_id,
    input  logic [3:0]        i_len,
    input  logic              i_rready,
    output logic              o_rvalid,
    output logic [ID_W-1:0]   o_rid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rlast,
    output logic              o_done
);

    logic [3:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == i_len);

    // Counter parks at zero whenever the block is idle, so every burst starts fresh.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (i_rready) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

    assign o_rvalid = i_en;
    assign o_rid    = i_id;
    assign o_rdata  = '0;
    assign o_rresp  = DECERR;
    assign o_rlast  = w_last;
    assign o_done   = i_en & i_rready & w_last;

endmodule

// File: rtl/axi_read_decoder.sv
// AXI read decoder: routes one outstanding AR to slave 0, slave 1 or the internal
// default slave, and steers the R burst back upstream; rd_done marks burst completion.
module axi_read_decoder
    import axi_pkg::*;
#(
    parameter int                ADDR_W  = AXI_ADDR_W,
    parameter int                DATA_W  = AXI_DATA_W,
    parameter int                ID_W    = AXI_ID_W,
    parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_DEF),
    parameter logic [ADDR_W-1:0] S0_MASK = ADDR_W'(S0_MASK_DEF),
    parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_DEF),
    parameter logic [ADDR_W-1:0] S1_MASK = ADDR_W'(S1_MASK_DEF)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // upstream AR
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    // upstream R
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    // slave 0
    output logic [ID_W-1:0]   ARID_S0,
    output logic [ADDR_W-1:0] ARADDR_S0,
    output logic [3:0]        ARLEN_S0,
    output logic [2:0]        ARSIZE_S0,
    output logic [1:0]        ARBURST_S0,
    output logic              ARVALID_S0,
    input  logic              ARREADY_S0,
    input  logic [ID_W-1:0]   RID_S0,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [1:0]        RRESP_S0,
    input  logic              RLAST_S0,
    input  logic              RVALID_S0,
    output logic              RREADY_S0,
    // slave 1
    output logic [ID_W-1:0]   ARID_S1,
    output logic [ADDR_W-1:0] ARADDR_S1,
    output logic [3:0]        ARLEN_S1,
    output logic [2:0]        ARSIZE_S1,
    output logic [1:0]        ARBURST_S1,
    output logic              ARVALID_S1,
    input  logic              ARREADY_S1,
    input  logic [ID_W-1:0]   RID_S1,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [1:0]        RRESP_S1,
    input  logic              RLAST_S1,
    input  logic              RVALID_S1,
    output logic              RREADY_S1,
    output logic              rd_done
);

    state_t            r_state;
    state_t            w_nxt;
    target_t           r_tgt;
    target_t           w_dec;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [3:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;
    logic              r_rd_done;
    logic              w_ar_hs;
    logic              w_last_hs;
    logic              w_derr_en;

    logic              w_dr_rvalid;
    logic [ID_W-1:0]   w_dr_rid;
    logic [DATA_W-1:0] w_dr_rdata;
    logic [1:0]        w_dr_rresp;
    logic              w_dr_rlast;
    logic              w_dr_done;

    // Slave 0 is checked first so overlapping windows resolve to it.
    always_comb begin
        if ((ARADDR & ~S0_MASK) == S0_BASE) begin
            w_dec = TGT_S0;
        end else if ((ARADDR & ~S1_MASK) == S1_BASE) begin
            w_dec = TGT_S1;
        end else begin
            w_dec = TGT_DEF;
        end
    end

    assign w_ar_hs   = ARVALID & ARREADY;
    assign w_derr_en = (r_state == DERR);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_tgt     <= TGT_S0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= w_last_hs;
            if (w_ar_hs) begin
                r_tgt     <= w_dec;
                r_arid    <= ARID;
                r_araddr  <= ARADDR;
                r_arlen   <= ARLEN;
                r_arsize  <= ARSIZE;
                r_arburst <= ARBURST;
            end
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_last_hs  = 1'b0;
        ARREADY    = 1'b0;
        ARVALID_S0 = 1'b0;
        ARVALID_S1 = 1'b0;
        RREADY_S0  = 1'b0;
        RREADY_S1  = 1'b0;
        RVALID     = 1'b0;
        RID        = '0;
        RDATA      = '0;
        RRESP      = '0;
        RLAST      = 1'b0;
        case (r_state)
            IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    w_nxt = (w_dec == TGT_DEF) ? DERR : ADDR;
                end
            end
            ADDR: begin
                if (r_tgt == TGT_S0) begin
                    ARVALID_S0 = 1'b1;
                    if (ARREADY_S0) w_nxt = DATA;
                end else begin
                    ARVALID_S1 = 1'b1;
                    if (ARREADY_S1) w_nxt = DATA;
                end
            end
            DATA: begin
                // The unselected slave sees RREADY low and its RVALID never reaches upstream.
                if (r_tgt == TGT_S0) begin
                    RVALID    = RVALID_S0;
                    RID       = RID_S0;
                    RDATA     = RDATA_S0;
                    RRESP     = RRESP_S0;
                    RLAST     = RLAST_S0;
                    RREADY_S0 = RREADY;
                    w_last_hs = RVALID_S0 & RREADY & RLAST_S0;
                end else begin
                    RVALID    = RVALID_S1;
                    RID       = RID_S1;
                    RDATA     = RDATA_S1;
                    RRESP     = RRESP_S1;
                    RLAST     = RLAST_S1;
                    RREADY_S1 = RREADY;
                    w_last_hs = RVALID_S1 & RREADY & RLAST_S1;
                end
                if (w_last_hs) w_nxt = IDLE;
            end
            DERR: begin
                RVALID    = w_dr_rvalid;
                RID       = w_dr_rid;
                RDATA     = w_dr_rdata;
                RRESP     = w_dr_rresp;
                RLAST     = w_dr_rlast;
                w_last_hs = w_dr_done;
                if (w_dr_done) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign ARID_S0    = r_arid;
    assign ARADDR_S0  = r_araddr;
    assign ARLEN_S0   = r_arlen;
    assign ARSIZE_S0  = r_arsize;
    assign ARBURST_S0 = r_arburst;
    assign ARID_S1    = r_arid;
    assign ARADDR_S1  = r_araddr;
    assign ARLEN_S1   = r_arlen;
    assign ARSIZE_S1  = r_arsize;
    assign ARBURST_S1 = r_arburst;
    assign rd_done    = r_rd_done;

    axi_default_slave #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W)
    ) u_def (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .i_en     (w_derr_en),
        .i_id     (r_arid),
        .i_len    (r_arlen),
        .i_rready (RREADY),
        .o_rvalid (w_dr_rvalid),
        .o_rid    (w_dr_rid),
        .o_rdata  (w_dr_rdata),
        .o_rresp  (w_dr_rresp),
        .o_rlast  (w_dr_rlast),
        .o_done   (w_dr_done)
    );

endmodule

// File: tb/tb_axi_read_decoder.sv
// Scoreboard bench for axi_read_decoder: expected upstream R beats are queued at issue time.
module tb_axi_read_decoder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          ACLK;
    logic          ARESETn;
    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [3:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic [IW-1:0] ARID_S0, ARID_S1;
    logic [AW-1:0] ARADDR_S0, ARADDR_S1;
    logic [3:0]    ARLEN_S0, ARLEN_S1;
    logic [2:0]    ARSIZE_S0, ARSIZE_S1;
    logic [1:0]    ARBURST_S0, ARBURST_S1;
    logic          ARVALID_S0, ARVALID_S1;
    logic          RREADY_S0, RREADY_S1;
    logic          rd_done;

    logic          s_arready [2];
    logic [IW-1:0] s_rid     [2];
    logic [DW-1:0] s_rdata   [2];
    logic [1:0]    s_rresp   [2];
    logic          s_rlast   [2];
    logic          s_rvalid  [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rr_low   = 0;
    bit rr_rand  = 0;
    bit stab_chk = 0;
    bit leak_chk = 0;
    int done_cnt, arv_cnt0, arv_cnt1, rrs1_cnt, done_cyc, acc_cyc;
    logic [42:0] sb_q[$];

    axi_read_decoder u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .ARID_S0(ARID_S0), .ARADDR_S0(ARADDR_S0), .ARLEN_S0(ARLEN_S0), .ARSIZE_S0(ARSIZE_S0),
        .ARBURST_S0(ARBURST_S0), .ARVALID_S0(ARVALID_S0), .ARREADY_S0(s_arready[0]),
        .RID_S0(s_rid[0]), .RDATA_S0(s_rdata[0]), .RRESP_S0(s_rresp[0]), .RLAST_S0(s_rlast[0]),
        .RVALID_S0(s_rvalid[0]), .RREADY_S0(RREADY_S0),
        .ARID_S1(ARID_S1), .ARADDR_S1(ARADDR_S1), .ARLEN_S1(ARLEN_S1), .ARSIZE_S1(ARSIZE_S1),
        .ARBURST_S1(ARBURST_S1), .ARVALID_S1(ARVALID_S1), .ARREADY_S1(s_arready[1]),
        .RID_S1(s_rid[1]), .RDATA_S1(s_rdata[1]), .RRESP_S1(s_rresp[1]), .RLAST_S1(s_rlast[1]),
        .RVALID_S1(s_rvalid[1]), .RREADY_S1(RREADY_S1),
        .rd_done(rd_done)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h @cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic arv(input int s);
        return (s == 0) ? ARVALID_S0 : ARVALID_S1;
    endfunction
    function automatic logic rrdy_s(input int s);
        return (s == 0) ? RREADY_S0 : RREADY_S1;
    endfunction
    function automatic logic [AW-1:0] araddr_s(input int s);
        return (s == 0) ? ARADDR_S0 : ARADDR_S1;
    endfunction
    function automatic logic [IW-1:0] arid_s(input int s);
        return (s == 0) ? ARID_S0 : ARID_S1;
    endfunction
    function automatic logic [3:0] arlen_s(input int s);
        return (s == 0) ? ARLEN_S0 : ARLEN_S1;
    endfunction

    // Upstream RREADY: optional forced-low window, otherwise random or always high.
    initial forever begin
        @(posedge ACLK);
        #2;
        if (rr_low > 0) begin
            RREADY = 1'b0;
            rr_low--;
        end else if (rr_rand) begin
            RREADY = 1'($urandom_range(0, 1));
        end else begin
            RREADY = 1'b1;
        end
    end

    // Monitor: scoreboard pop, rd_done timing, stall stability, leak and activity counters.
    logic        exp_done   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [43:0] prev_snap  = '0;
    initial forever begin
        logic [42:0] exp_b;
        logic [43:0] snap;
        @(negedge ACLK);
        if (rd_done || exp_done) chk("rd_done", 64'(rd_done), 64'(exp_done));
        if (rd_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        exp_done = RVALID && RREADY && RLAST && ARESETn;
        if (RVALID && RREADY) begin
            chk("beat_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                exp_b = sb_q.pop_front();
                chk("rbeat", 64'({RID, RDATA, RRESP, RLAST}), 64'(exp_b));
            end
        end
        snap = {RVALID, RID, RDATA, RRESP, RLAST};
        if (stab_chk && prev_stall) chk("stall_hold", 64'(snap), 64'(prev_snap));
        prev_stall = RVALID && !RREADY;
        prev_snap  = snap;
        arv_cnt0 += int'(ARVALID_S0);
        arv_cnt1 += int'(ARVALID_S1);
        rrs1_cnt += int'(RREADY_S1);
        if (leak_chk && s_rvalid[1] && s_rdata[1] == 32'hDEAD_BEEF)
            chk("s1_leak_rready", 64'(RREADY_S1), 64'd0);
    end

    task automatic clr_stats();
        done_cnt = 0; arv_cnt0 = 0; arv_cnt1 = 0; rrs1_cnt = 0; done_cyc = -1; acc_cyc = -2;
    endtask

    task automatic push_beats(input logic [IW-1:0] id, input logic [DW-1:0] dbase,
                              input logic [1:0] resp, input int n, input bit is_def);
        for (int i = 0; i < n; i++)
            sb_q.push_back({id, is_def ? 32'd0 : dbase + DW'(i), resp, 1'(i == n - 1)});
    endtask

    task automatic wait_arready(output int c);
        int t = 0;
        @(negedge ACLK);
        while (!ARREADY && t < 300) begin
            @(negedge ACLK);
            t++;
        end
        chk("arready_wait", 64'(ARREADY), 64'd1);
        c = cyc;
    endtask

    task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len);
        int c;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = 2'b01;
        wait_arready(c);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
    endtask

    // Slave model: accepts AR after ar_lat cycles, returns n beats; stop_after leaves a beat dangling.
    task automatic slave_serve(input int s, input int ar_lat, input int n, input int stop_after,
                               input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                               input logic [DW-1:0] dbase, input logic [1:0] resp, input int stall0);
        int t = 0;
        @(negedge ACLK);
        while (!arv(s) && t < 300) begin
            @(negedge ACLK);
            t++;
        end
        chk("ar_valid_s", 64'(arv(s)), 64'd1);
        if (!arv(s)) return;
        repeat (ar_lat) begin
            @(negedge ACLK);
            chk("ar_hold_s", 64'({arv(s), araddr_s(s)}), 64'({1'b1, addr}));
        end
        @(posedge ACLK);
        #1 s_arready[s] = 1'b1;
        @(negedge ACLK);
        chk("ar_id_s", 64'(arid_s(s)), 64'(id));
        chk("ar_addr_s", 64'(araddr_s(s)), 64'(addr));
        chk("ar_len_s", 64'(arlen_s(s)), 64'(len));
        @(posedge ACLK);
        #1 s_arready[s] = 1'b0;
        for (int b = 0; b < n; b++) begin
            s_rvalid[s] = 1'b1; s_rid[s] = id; s_rdata[s] = dbase + DW'(b);
            s_rresp[s] = resp; s_rlast[s] = (b == n - 1);
            if (b == 0 && stall0 > 0) rr_low = stall0;
            if (b == stop_after) return;
            t = 0;
            @(negedge ACLK);
            while (!rrdy_s(s) && t < 300) begin
                @(negedge ACLK);
                t++;
            end
            chk("r_ready_s", 64'(rrdy_s(s)), 64'd1);
            @(posedge ACLK);
            #1;
        end
        s_rvalid[s] = 1'b0; s_rlast[s] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (sb_q.size() > 0 && t < 400) begin
            @(negedge ACLK);
            t++;
        end
        chk(tag, 64'(sb_q.size()), 64'd0);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    initial begin
        int c;
        ARESETn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_arready[i] = 1'b0; s_rid[i] = '0; s_rdata[i] = '0;
            s_rresp[i] = '0; s_rlast[i] = 1'b0; s_rvalid[i] = 1'b0;
        end
        clr_stats();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_arvalid_s", 64'({ARVALID_S0, ARVALID_S1}), 64'd0);
        chk("rst_rready_s", 64'({RREADY_S0, RREADY_S1}), 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        // S0 burst of 4, slave AR ready after 2 cycles
        clr_stats();
        push_beats(8'h11, 32'hA000_0000, 2'd0, 4, 0);
        fork
            issue_ar(8'h11, 32'h0000_0040, 4'd3);
            slave_serve(0, 2, 4, -1, 8'h11, 32'h0000_0040, 4'd3, 32'hA000_0000, 2'd0, 0);
        join
        wait_drain("t1_drain");
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_arv_s1", 64'(arv_cnt1), 64'd0);
        chk("t1_rready_s1", 64'(rrs1_cnt), 64'd0);

        // S1 single beat with upstream stall
        clr_stats();
        push_beats(8'h22, 32'hC000_0010, 2'd1, 1, 0);
        fork
            issue_ar(8'h22, 32'h0001_0100, 4'd0);
            slave_serve(1, 0, 1, -1, 8'h22, 32'h0001_0100, 4'd0, 32'hC000_0010, 2'd1, 3);
        join
        wait_drain("t2_drain");
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        chk("t2_arv_s0", 64'(arv_cnt0), 64'd0);

        // Default slave, 3 beats
        clr_stats();
        push_beats(8'h25, 32'd0, 2'b11, 3, 1);
        issue_ar(8'h25, 32'h8000_0000, 4'd2);
        wait_drain("t3_drain");
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_arv_any", 64'(arv_cnt0 + arv_cnt1), 64'd0);

        // Just past the S1 window decodes to the default slave
        clr_stats();
        push_beats(8'h26, 32'd0, 2'b11, 1, 1);
        issue_ar(8'h26, 32'h0002_0000, 4'd0);
        wait_drain("t3b_drain");
        chk("t3b_arv_any", 64'(arv_cnt0 + arv_cnt1), 64'd0);

        // Default slave, 16 beats with random stalls
        clr_stats();
        rr_rand = 1'b1; stab_chk = 1'b1;
        push_beats(8'h5A, 32'd0, 2'b11, 16, 1);
        issue_ar(8'h5A, 32'hFFFF_0000, 4'd15);
        wait_drain("t4_drain");
        rr_rand = 1'b0; stab_chk = 1'b0;
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);

        // Reset during S0 beat 2, then a fresh read at the top of the S0 window
        clr_stats();
        push_beats(8'h33, 32'hB000_0000, 2'd0, 4, 0);
        fork
            issue_ar(8'h33, 32'h0000_0080, 4'd3);
            slave_serve(0, 0, 4, 1, 8'h33, 32'h0000_0080, 4'd3, 32'hB000_0000, 2'd0, 0);
        join
        ARESETn = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("mrst_rvalid", 64'(RVALID), 64'd0);
        chk("mrst_arready", 64'(ARREADY), 64'd1);
        chk("mrst_rd_done", 64'(rd_done), 64'd0);
        chk("mrst_s_valid_ready", 64'({ARVALID_S0, ARVALID_S1, RREADY_S0, RREADY_S1}), 64'd0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1; s_rvalid[0] = 1'b0; s_rlast[0] = 1'b0;
        sb_q.delete();
        clr_stats();
        push_beats(8'h34, 32'hB100_0000, 2'd0, 2, 0);
        fork
            issue_ar(8'h34, 32'h0000_FFFC, 4'd1);
            slave_serve(0, 1, 2, -1, 8'h34, 32'h0000_FFFC, 4'd1, 32'hB100_0000, 2'd0, 0);
        join
        wait_drain("t5_drain");
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);

        // Back-to-back ARs with ARVALID held; S1 asserts a stray RVALID while S0 is selected
        clr_stats();
        s_rvalid[1] = 1'b1; s_rdata[1] = 32'hDEAD_BEEF; s_rid[1] = 8'hEE; s_rlast[1] = 1'b1;
        leak_chk = 1'b1;
        push_beats(8'h41, 32'hD000_0000, 2'd0, 2, 0);
        push_beats(8'h42, 32'hE000_0000, 2'd1, 1, 0);
        fork
            begin
                ARVALID = 1'b1; ARID = 8'h41; ARADDR = 32'h0000_0200; ARLEN = 4'd1;
                ARSIZE = 3'd2; ARBURST = 2'b01;
                wait_arready(c);
                @(posedge ACLK);
                #1 ARID = 8'h42; ARADDR = 32'h0001_0004; ARLEN = 4'd0;
                wait_arready(c);
                acc_cyc = c;
                @(posedge ACLK);
                #1 ARVALID = 1'b0;
            end
            slave_serve(0, 1, 2, -1, 8'h41, 32'h0000_0200, 4'd1, 32'hD000_0000, 2'd0, 0);
            slave_serve(1, 0, 1, -1, 8'h42, 32'h0001_0004, 4'd0, 32'hE000_0000, 2'd1, 0);
        join
        wait_drain("t6_drain");
        leak_chk = 1'b0;
        chk("t6_accept_at_done", 64'(acc_cyc), 64'(done_cyc));
        chk("t6_done_cnt", 64'(done_cnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
